// File: rtl/sw_arb_pkg.sv
// Shared types and limits for the software access port arbiter.
package sw_arb_pkg;

  localparam int unsigned ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } sw_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr wins, with wrap-around.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  int unsigned   pos;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      idx = PW'(pos);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_access_arb.sv
// Shares one sw_ctrl access port among REQ_N requesters with round-robin arbitration.
// Optional response timeout enabled by defining SW_ARB_RSP_TIMEOUT_EN.
module sw_access_arb
  import sw_arb_pkg::*;
#(
  parameter int unsigned F_WIDTH     = 4,
  parameter int unsigned REQ_N       = 2,
  parameter int unsigned RSP_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REQ_N-1:0]           req_vld,
  input  logic [REQ_N-1:0]           req_wr,
  input  logic [F_WIDTH*REQ_N-1:0]   req_wdata,
  output logic [REQ_N-1:0]           req_rdy,
  output logic [REQ_N-1:0]           rsp_vld,
  input  logic [REQ_N-1:0]           rsp_rdy,
  output logic [F_WIDTH-1:0]         rsp_rdata,
  output logic                       rsp_err,
  output logic                       sw_wr,
  output logic                       sw_rd,
  output logic [F_WIDTH-1:0]         sw_wr_data,
  input  logic [F_WIDTH-1:0]         field_value
);

  localparam int unsigned PW = $clog2(REQ_N);

  if (REQ_N < 2 || REQ_N > ARB_MAX_REQ) begin : g_req_n_check
    $error("sw_access_arb: REQ_N out of range");
  end

  sw_arb_state_t      state_q, state_d;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      gnt_idx_q;
  logic [PW-1:0]      ptr_nxt;
  logic [REQ_N-1:0]   gnt_q;
  logic [REQ_N-1:0]   arb_gnt;
  logic [PW-1:0]      sel_idx;
  logic               sel_wr;
  logic [F_WIDTH-1:0] sel_wdata;
  logic               xfer;
  logic               rsp_hit;
  logic               tmo_hit;
  logic               tmo_drop;
  logic               rsp_end;

  rr_arbiter #(.N(REQ_N), .PW(PW)) u_rr_arbiter (
    .req (req_vld),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Mux the winner's command fields out of the flat request buses
  always_comb begin
    sel_idx   = '0;
    sel_wr    = 1'b0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < REQ_N; i++) begin
      if (arb_gnt[i]) begin
        sel_idx   = sel_idx | PW'(i);
        sel_wr    = sel_wr | req_wr[i];
        sel_wdata = sel_wdata | req_wdata[i*F_WIDTH +: F_WIDTH];
      end
    end
  end

  assign ptr_nxt = (gnt_idx_q == PW'(REQ_N - 1)) ? '0 : gnt_idx_q + PW'(1);
  assign rsp_hit = |(rsp_rdy & gnt_q);

  // Next state and handshake decode
  always_comb begin
    state_d  = state_q;
    req_rdy  = '0;
    xfer     = 1'b0;
    tmo_drop = 1'b0;
    rsp_end  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        req_rdy = arb_gnt;
        if (|req_vld) begin
          xfer    = 1'b1;
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (rsp_hit) begin
          rsp_end = 1'b1;
          state_d = ARB_IDLE;
        end else if (tmo_hit) begin
          tmo_drop = 1'b1;
          rsp_end  = 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      sw_wr      <= 1'b0;
      sw_rd      <= 1'b0;
      sw_wr_data <= '0;
      rsp_vld    <= '0;
      rsp_rdata  <= '0;
    end else begin
      state_q <= state_d;
      sw_wr   <= 1'b0;
      sw_rd   <= 1'b0;
      if (xfer) begin
        gnt_q      <= arb_gnt;
        gnt_idx_q  <= sel_idx;
        sw_wr      <= sel_wr;
        sw_rd      <= ~sel_wr;
        sw_wr_data <= sel_wdata;
      end
      // Capture happens alongside the strobe, so read-side effects return the old value
      if (state_q == ARB_ACCESS) begin
        rsp_rdata <= sw_wr ? '0 : field_value;
        rsp_vld   <= gnt_q;
      end
      if (rsp_end) begin
        rsp_vld <= '0;
        ptr_q   <= ptr_nxt;
      end
    end
  end

`ifdef SW_ARB_RSP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(RSP_TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_q;

  assign tmo_hit = (tmo_cnt_q == TW'(RSP_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      rsp_err   <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == ARB_RESP) ? tmo_cnt_q + TW'(1) : '0;
      rsp_err   <= tmo_drop;
    end
  end
`else
  localparam int unsigned TW = $clog2(RSP_TIMEOUT + 1);

  logic [TW-1:0] unused_tmo;

  assign unused_tmo = TW'(RSP_TIMEOUT);
  assign tmo_hit    = 1'b0;
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sw_access_arb.sv
// Randomized self-checking bench for sw_access_arb with a transaction-level reference model.
module tb_sw_access_arb;

  localparam int unsigned F_WIDTH = 4;
  localparam int unsigned REQ_N   = 2;
  localparam int unsigned RSP_TO  = 3;

  logic                     clk;
  logic                     rst_n;
  logic [REQ_N-1:0]         req_vld;
  logic [REQ_N-1:0]         req_wr;
  logic [F_WIDTH*REQ_N-1:0] req_wdata;
  logic [REQ_N-1:0]         req_rdy;
  logic [REQ_N-1:0]         rsp_vld;
  logic [REQ_N-1:0]         rsp_rdy;
  logic [F_WIDTH-1:0]       rsp_rdata;
  logic                     rsp_err;
  logic                     sw_wr;
  logic                     sw_rd;
  logic [F_WIDTH-1:0]       sw_wr_data;
  logic [F_WIDTH-1:0]       field_value;

  int          n_chk = 0;
  int          n_err = 0;
  int unsigned ptr_m = 0;

  sw_access_arb #(
    .F_WIDTH     (F_WIDTH),
    .REQ_N       (REQ_N),
    .RSP_TIMEOUT (RSP_TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_vld     (req_vld),
    .req_wr      (req_wr),
    .req_wdata   (req_wdata),
    .req_rdy     (req_rdy),
    .rsp_vld     (rsp_vld),
    .rsp_rdy     (rsp_rdy),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .sw_wr       (sw_wr),
    .sw_rd       (sw_rd),
    .sw_wr_data  (sw_wr_data),
    .field_value (field_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference winner: scan upward from the rotating pointer with wrap-around
  function automatic int unsigned pick(input logic [REQ_N-1:0] vld, input int unsigned p);
    for (int unsigned k = 0; k < REQ_N; k++) begin
      if (vld[(p + k) % REQ_N]) return (p + k) % REQ_N;
    end
    return REQ_N;
  endfunction

  // One full transaction starting at a negedge with the DUT idle
  task automatic txn(input logic [REQ_N-1:0] vld, input logic [REQ_N-1:0] wr,
                     input logic [F_WIDTH*REQ_N-1:0] wd, input logic [F_WIDTH-1:0] fv,
                     input int unsigned stall);
    int unsigned        g;
    logic               exp_wr;
    logic [F_WIDTH-1:0] exp_wd;
    logic [F_WIDTH-1:0] exp_rd;
    logic [REQ_N-1:0]   rr;
    req_vld     = vld;
    req_wr      = wr;
    req_wdata   = wd;
    field_value = ~fv;
    rsp_rdy     = '0;
    #1;
    chk("idle_rsp_vld", 32'(rsp_vld), 0);
    chk("idle_rsp_err", 32'(rsp_err), 0);
    chk("idle_strobes", 32'({sw_wr, sw_rd}), 0);
    g = pick(vld, ptr_m);
    if (g == REQ_N) begin
      chk("idle_req_rdy", 32'(req_rdy), 0);
      @(negedge clk);
      return;
    end
    chk("req_rdy", 32'(req_rdy), 32'(1) << g);
    exp_wr = wr[g];
    exp_wd = wd[g*F_WIDTH +: F_WIDTH];
    exp_rd = exp_wr ? '0 : fv;

    @(negedge clk);
    field_value = fv;
    #1;
    chk("acc_sw_wr", 32'(sw_wr), 32'(exp_wr));
    chk("acc_sw_rd", 32'(sw_rd), 32'(!exp_wr));
    chk("acc_wr_data", 32'(sw_wr_data), 32'(exp_wd));
    chk("acc_req_rdy", 32'(req_rdy), 0);
    chk("acc_rsp_vld", 32'(rsp_vld), 0);

    for (int unsigned k = 0; k <= stall; k++) begin
      @(negedge clk);
      field_value = F_WIDTH'($urandom);
      rr          = REQ_N'($urandom);
      rr[g]       = (k == stall);
`ifdef SW_ARB_RSP_TIMEOUT_EN
      if (k == RSP_TO) begin
        rsp_rdy = '0;
        req_vld = '0;
        #1;
        chk("tmo_rsp_vld", 32'(rsp_vld), 0);
        chk("tmo_rsp_err", 32'(rsp_err), 1);
        chk("tmo_req_rdy", 32'(req_rdy), 0);
        ptr_m = (g + 1) % REQ_N;
        @(negedge clk);
        return;
      end
`endif
      rsp_rdy = rr;
      #1;
      chk("rsp_vld", 32'(rsp_vld), 32'(1) << g);
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
      chk("rsp_req_rdy", 32'(req_rdy), 0);
      chk("rsp_strobes", 32'({sw_wr, sw_rd}), 0);
      chk("rsp_err_low", 32'(rsp_err), 0);
    end
    @(negedge clk);
    rsp_rdy = '0;
    ptr_m   = (g + 1) % REQ_N;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_vld     = '0;
    req_wr      = '0;
    req_wdata   = '0;
    rsp_rdy     = '0;
    field_value = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_outputs", 32'({req_rdy, rsp_vld, rsp_rdata, rsp_err, sw_wr, sw_rd, sw_wr_data}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic read, then write from requester 1
    txn(2'b01, 2'b00, 8'h00, 4'hA, 0);
    txn(2'b10, 2'b10, 8'h50, 4'h3, 0);
    // Contention: grants must alternate
    for (int i = 0; i < 4; i++) begin
      txn(2'b11, REQ_N'($urandom), F_WIDTH*REQ_N'($urandom), F_WIDTH'($urandom), i);
    end
    // Back-pressure (times out when the timeout build is selected)
    txn(2'b01, 2'b00, 8'h00, 4'h6, 5);

    // Reset during ACCESS drops the transaction and rewinds the pointer
    txn(2'b01, 2'b00, 8'h00, 4'h2, 0);
    req_vld   = 2'b10;
    req_wr    = 2'b00;
    req_wdata = 8'hF0;
    #1;
    chk("mid_req_rdy", 32'(req_rdy), 32'(2'b10));
    @(negedge clk);
    #1;
    chk("mid_sw_rd", 32'(sw_rd), 1);
    chk("mid_wr_data", 32'(sw_wr_data), 32'h F);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    req_vld = '0;
    #1;
    chk("mid_rst_outputs", 32'({req_rdy, rsp_vld, rsp_rdata, rsp_err, sw_wr, sw_rd, sw_wr_data}), 0);
    ptr_m = 0;
    @(negedge clk);
    txn(2'b11, 2'b00, 8'h00, 4'h9, 0);

    for (int i = 0; i < 200; i++) begin
      txn(REQ_N'($urandom), REQ_N'($urandom), (F_WIDTH*REQ_N)'($urandom),
          F_WIDTH'($urandom), $urandom_range(0, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
